// File: rtl/whack_pkg.sv
// Shared types and helpers for the whack-a-mole game sequencer.
package whack_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNTDOWN,
    PLAY,
    OVER
  } state_t;

  localparam int unsigned SPEED_W = 28;
  localparam logic [1:0] LEVEL_MAX = 2'd3;

  // Mole on-time for a level; never drops below one decrement step and never wraps.
  function automatic logic [SPEED_W-1:0] speed_for_level(
    input logic [1:0]         lvl,
    input logic [SPEED_W-1:0] base,
    input logic [SPEED_W-1:0] dec
  );
    logic [31:0]        prod;
    logic [SPEED_W-1:0] res;
    prod = 32'(lvl) * 32'(dec);
    if (32'(base) < prod + 32'(dec)) res = dec;
    else res = SPEED_W'(32'(base) - prod);
    return res;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock down to a one-cycle tick every CLK_HZ cycles; clear holds the count at zero
// so the first tick lands exactly CLK_HZ cycles after clear is released.
module tick_prescaler #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CNT_W-1:0] r_count;

  assign tick = (r_count == CNT_W'(CLK_HZ - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) r_count <= '0;
    else if (tick)      r_count <= '0;
    else                r_count <= r_count + 1'b1;
  end

endmodule

// File: rtl/whack_game_controller.sv
// Game sequencer: start countdown, timed round, score-driven level/speed, game-over hold.
// Optional best-score register enabled by defining WHACK_HISCORE_EN.
module whack_game_controller
  import whack_pkg::*;
#(
  parameter int unsigned        CLK_HZ            = 50_000_000,
  parameter int unsigned        ROUND_SECONDS     = 60,
  parameter int unsigned        COUNTDOWN_SECONDS = 3,
  parameter int unsigned        LEVEL_STEP        = 5,
  parameter logic [SPEED_W-1:0] BASE_SPEED        = 28'd99_999_999,
  parameter logic [SPEED_W-1:0] SPEED_DEC         = 28'd25_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         score,
  output logic               game,
  output logic [SPEED_W-1:0] speed,
  output logic [1:0]         level,
  output logic [7:0]         time_left,
  output logic               game_over,
  output logic [7:0]         hiscore
);

  state_t             r_state, w_state_next;
  logic               r_start_q;
  logic               w_tick, w_clear, w_start_rise;
  logic [7:0]         r_time_left, w_time_next;
  logic [1:0]         r_level, w_level_next, w_target;
  logic [7:0]         w_quot;
  logic [SPEED_W-1:0] r_speed;
  logic               r_game, r_game_over;

  assign w_clear      = (r_state == IDLE) || (r_state == OVER);
  assign w_start_rise = start && !r_start_q;
  assign w_quot       = score / 8'(LEVEL_STEP);
  assign w_target     = (w_quot > 8'(LEVEL_MAX)) ? LEVEL_MAX : w_quot[1:0];

  tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // Dropping start always wins, including over a coincident final tick.
  always_comb begin
    w_state_next = r_state;
    w_time_next  = r_time_left;
    case (r_state)
      IDLE: begin
        w_time_next = '0;
        if (w_start_rise) begin
          w_state_next = COUNTDOWN;
          w_time_next  = 8'(COUNTDOWN_SECONDS);
        end
      end
      COUNTDOWN: begin
        if (!start) begin
          w_state_next = IDLE;
          w_time_next  = '0;
        end else if (w_tick) begin
          if (r_time_left == 8'd1) begin
            w_state_next = PLAY;
            w_time_next  = 8'(ROUND_SECONDS);
          end else begin
            w_time_next = r_time_left - 8'd1;
          end
        end
      end
      PLAY: begin
        if (!start) begin
          w_state_next = IDLE;
          w_time_next  = '0;
        end else if (w_tick) begin
          if (r_time_left == 8'd1) begin
            w_state_next = OVER;
            w_time_next  = '0;
          end else begin
            w_time_next = r_time_left - 8'd1;
          end
        end
      end
      OVER: begin
        w_time_next = '0;
        if (!start) w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
        w_time_next  = '0;
      end
    endcase
  end

  // Level only ratchets upward during play; it is zeroed on the way into a round or back to idle.
  always_comb begin
    w_level_next = r_level;
    if (w_state_next == IDLE || r_state == COUNTDOWN) w_level_next = '0;
    else if (r_state == PLAY && w_target > r_level)   w_level_next = w_target;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_start_q   <= start;
      r_time_left <= '0;
      r_level     <= '0;
      r_speed     <= BASE_SPEED;
      r_game      <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_start_q   <= start;
      r_time_left <= w_time_next;
      r_level     <= w_level_next;
      r_speed     <= (w_state_next == IDLE) ? BASE_SPEED
                                            : speed_for_level(r_level, BASE_SPEED, SPEED_DEC);
      r_game      <= (w_state_next == PLAY);
      r_game_over <= (w_state_next == OVER);
    end
  end

  assign game      = r_game;
  assign speed     = r_speed;
  assign level     = r_level;
  assign time_left = r_time_left;
  assign game_over = r_game_over;

`ifdef WHACK_HISCORE_EN
  logic [7:0] r_hiscore;

  always_ff @(posedge clock) begin
    if (reset) r_hiscore <= '0;
    else if (r_state == PLAY && w_state_next == OVER && score > r_hiscore) r_hiscore <= score;
  end

  assign hiscore = r_hiscore;
`else
  assign hiscore = '0;
`endif

endmodule

// File: tb/tb_whack_game_controller.sv
// Directed bench for whack_game_controller with a 10-cycle second, 5 s round, 3 s countdown.
module tb_whack_game_controller;

  localparam int unsigned CLK_HZ = 10;
  localparam int unsigned BASE   = 99_999_999;

`ifdef WHACK_HISCORE_EN
  localparam int unsigned HI_AFTER_7 = 7;
`else
  localparam int unsigned HI_AFTER_7 = 0;
`endif

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  score;
  logic        game;
  logic [27:0] speed;
  logic [1:0]  level;
  logic [7:0]  time_left;
  logic        game_over;
  logic [7:0]  hiscore;

  int n_checks = 0;
  int n_errors = 0;

  whack_game_controller #(
    .CLK_HZ            (CLK_HZ),
    .ROUND_SECONDS     (5),
    .COUNTDOWN_SECONDS (3),
    .LEVEL_STEP        (5)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .score     (score),
    .game      (game),
    .speed     (speed),
    .level     (level),
    .time_left (time_left),
    .game_over (game_over),
    .hiscore   (hiscore)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic [31:0] exp_hi);
    check({tag, "_game"}, 32'(game), 0);
    check({tag, "_over"}, 32'(game_over), 0);
    check({tag, "_time"}, 32'(time_left), 0);
    check({tag, "_level"}, 32'(level), 0);
    check({tag, "_speed"}, 32'(speed), BASE);
    check({tag, "_hi"}, 32'(hiscore), exp_hi);
  endtask

  // Raise start and run through the countdown; returns just after PLAY is entered.
  task automatic begin_round();
    start = 1'b1;
    step(1);
    step(30);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    score = 8'd0;
    step(3);
    check_idle("reset", 0);
    reset = 1'b0;
    step(1);

    // Round 1: countdown timing, then a full round with score 0.
    start = 1'b1;
    step(1);
    check("cd_entry_time", 32'(time_left), 3);
    check("cd_entry_game", 32'(game), 0);
    step(9);
    check("cd_before_tick", 32'(time_left), 3);
    step(1);
    check("cd_tick1", 32'(time_left), 2);
    step(10);
    check("cd_tick2", 32'(time_left), 1);
    step(9);
    check("cd_last_game", 32'(game), 0);
    step(1);
    check("play_entry_time", 32'(time_left), 5);
    check("play_entry_game", 32'(game), 1);
    check("play_entry_level", 32'(level), 0);
    step(49);
    check("play_last_time", 32'(time_left), 1);
    check("play_last_game", 32'(game), 1);
    step(1);
    check("over_game", 32'(game), 0);
    check("over_flag", 32'(game_over), 1);
    check("over_time", 32'(time_left), 0);
    check("over_hi0", 32'(hiscore), 0);
    step(5);
    check("over_hold_flag", 32'(game_over), 1);
    check("over_hold_time", 32'(time_left), 0);
    start = 1'b0;
    step(1);
    check_idle("over_to_idle", 0);

    // Round 2: level/speed progression, level never falls, round ends on score 7.
    begin_round();
    score = 8'd4;
    step(2);
    check("lvl_s4", 32'(level), 0);
    check("spd_s4", 32'(speed), BASE);
    score = 8'd5;
    step(1);
    check("lvl_s5", 32'(level), 1);
    check("spd_s5_lag", 32'(speed), BASE);
    step(1);
    check("spd_s5", 32'(speed), 74_999_999);
    score = 8'd12;
    step(2);
    check("lvl_s12", 32'(level), 2);
    check("spd_s12", 32'(speed), 49_999_999);
    score = 8'd20;
    step(2);
    check("lvl_s20", 32'(level), 3);
    check("spd_s20_clamp", 32'(speed), 25_000_000);
    score = 8'd3;
    step(2);
    check("lvl_hold", 32'(level), 3);
    check("spd_hold", 32'(speed), 25_000_000);
    check("time_mid", 32'(time_left), 4);
    score = 8'd7;
    step(40);
    check("r2_over", 32'(game_over), 1);
    check("r2_level_hold", 32'(level), 3);
    check("r2_speed_hold", 32'(speed), 25_000_000);
    check("r2_hi", 32'(hiscore), HI_AFTER_7);
    start = 1'b0;
    step(1);
    check_idle("r2_idle", HI_AFTER_7);

    // Round 3: lower final score keeps the best one.
    score = 8'd0;
    begin_round();
    score = 8'd4;
    step(50);
    check("r3_over", 32'(game_over), 1);
    check("r3_hi", 32'(hiscore), HI_AFTER_7);
    start = 1'b0;
    step(1);

    // Abort mid-play.
    score = 8'd0;
    begin_round();
    step(5);
    check("abort_pre_game", 32'(game), 1);
    start = 1'b0;
    step(1);
    check_idle("abort_mid", HI_AFTER_7);

    // Abort coincident with the final tick, with a higher score that must not be recorded.
    begin_round();
    score = 8'd9;
    step(49);
    check("coinc_pre_time", 32'(time_left), 1);
    start = 1'b0;
    step(1);
    check_idle("abort_coinc", HI_AFTER_7);
    step(2);
    check("abort_coinc_stay", 32'(game_over), 0);

    // Reset during countdown with start held high: no restart until start toggles.
    score = 8'd0;
    start = 1'b1;
    step(1);
    step(5);
    check("rst_cd_time", 32'(time_left), 3);
    reset = 1'b1;
    step(1);
    check_idle("rst_mid", 0);
    reset = 1'b0;
    step(15);
    check_idle("rst_no_restart", 0);
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    check("rst_retoggle_time", 32'(time_left), 3);
    check("rst_retoggle_game", 32'(game), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
